// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared CPU widths, reset vector and fetch-stage types.
package fetch_stage_pkg;
    localparam int PC_W = 32;
    localparam int INST_W = 32;
    localparam int FS_BUS_W = INST_W + PC_W;
    localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h1C000000;
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fs_bus_t;
    typedef enum logic [1:0] {IF_EMPTY, IF_LIVE, IF_HELD} if_state_e;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: decode handshake, redirect and instruction SRAM signals of the fetch stage.
interface fetch_stage_if;
    import fetch_stage_pkg::*;
    logic                allow_2;
    logic                br_taken;
    logic [PC_W-1:0]     br_target;
    logic                valid_1;
    logic [FS_BUS_W-1:0] stage_1_to_2;
    logic                inst_sram_en;
    logic [3:0]          inst_sram_we;
    logic [PC_W-1:0]     inst_sram_addr;
    logic [INST_W-1:0]   inst_sram_wdata;
    logic [INST_W-1:0]   inst_sram_rdata;
    modport master (
        input  allow_2, br_taken, br_target, inst_sram_rdata,
        output valid_1, stage_1_to_2, inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );
    modport slave (
        output allow_2, br_taken, br_target, inst_sram_rdata,
        input  valid_1, stage_1_to_2, inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );
endinterface

// File: rtl/fetch_inst_buffer.sv
// fetch_inst_buffer: one-entry hold register for an instruction the decode stage could not yet accept.
module fetch_inst_buffer
    import fetch_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic              clear,
    input  logic [INST_W-1:0] din,
    output logic              valid,
    output logic [INST_W-1:0] dout
);
    logic              valid_q, valid_d;
    logic [INST_W-1:0] inst_q, inst_d;
    always_comb begin
        valid_d = (reset | clear) ? 1'b0 : capture ? 1'b1 : valid_q;
        inst_d = reset ? '0 : capture ? din : inst_q;
    end
    always_ff @(posedge clk) begin
        valid_q <= valid_d;
        inst_q <= inst_d;
    end
    // SRAM data bypasses the buffer while nothing is held
    assign valid = valid_q;
    assign dout = valid_q ? inst_q : din;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: two-part instruction fetch (pre-IF request, IF hold) feeding the decode stage.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input logic          clk,
    input logic          reset,
    fetch_stage_if.master bus
);
    logic [PC_W-1:0]   pc_q, pc_d, nextpc;
    logic              if_valid_q, if_valid_d;
    logic              if_allowin, sram_en, capture, buf_valid;
    logic [INST_W-1:0] inst;
    if_state_e         if_state;
    fs_bus_t           out_bus;
    always_comb begin
        nextpc = bus.br_taken ? bus.br_target : pc_q + 32'd4;
        if_allowin = ~if_valid_q | bus.allow_2 | bus.br_taken;
        sram_en = ~reset & if_allowin;
        if_state = ~if_valid_q ? IF_EMPTY : buf_valid ? IF_HELD : IF_LIVE;
        capture = ~reset & (if_state == IF_LIVE) & ~bus.allow_2 & ~bus.br_taken;
        pc_d = reset ? RESET_PC - 32'd4 : sram_en ? nextpc : pc_q;
        if_valid_d = ~reset & (sram_en | if_valid_q);
        out_bus.inst = inst;
        out_bus.pc = pc_q;
    end
    always_ff @(posedge clk) begin
        pc_q <= pc_d;
        if_valid_q <= if_valid_d;
    end
    fetch_inst_buffer u_buf (
        .clk    (clk),
        .reset  (reset),
        .capture(capture),
        .clear  (sram_en),
        .din    (bus.inst_sram_rdata),
        .valid  (buf_valid),
        .dout   (inst)
    );
    // a redirect squashes the wrong-path instruction sitting in IF
    assign bus.valid_1 = if_valid_q & ~bus.br_taken & ~reset;
    assign bus.stage_1_to_2 = out_bus;
    assign bus.inst_sram_en = sram_en;
    assign bus.inst_sram_we = 4'h0;
    assign bus.inst_sram_addr = {nextpc[31:2], 2'b00};
    assign bus.inst_sram_wdata = '0;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random stimulus against a model of what the IF stage holds.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic reset;
    int passed = 0;
    int total = 0;
    logic m_live;
    logic [31:0] m_pc;
    fetch_stage_if bus ();
    fetch_stage dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h1C000008) ? 32'h02800C21 : ({a[15:0], ~a[31:16]} ^ 32'h13579BDF);
    endfunction
    // synchronous SRAM; returns noise whenever it was not enabled
    always @(posedge clk)
        bus.inst_sram_rdata <= bus.inst_sram_en ? mem(bus.inst_sram_addr) : $urandom;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed %h expected %h", tag, obs, exp);
    endtask
    task automatic step(input logic r, input logic a, input logic b, input logic [31:0] t);
        logic exp_en, exp_v;
        logic [31:0] exp_addr;
        reset = r;
        bus.allow_2 = a;
        bus.br_taken = b;
        bus.br_target = t;
        #1;
        exp_en = ~r & (~m_live | a | b);
        exp_addr = (b ? t : m_pc + 32'd4) & ~32'h3;
        exp_v = m_live & ~b;
        chk("sram_en", {63'd0, bus.inst_sram_en}, {63'd0, exp_en});
        if (exp_en) chk("sram_addr", {32'd0, bus.inst_sram_addr}, {32'd0, exp_addr});
        chk("sram_we_wdata", {28'd0, bus.inst_sram_we, bus.inst_sram_wdata}, 64'd0);
        if (!r) begin
            chk("valid_1", {63'd0, bus.valid_1}, {63'd0, exp_v});
            if (exp_v) chk("stage_1_to_2", bus.stage_1_to_2, {mem(m_pc), m_pc});
        end
        if (r) begin
            m_live = 1'b0;
            m_pc = 32'h1C000000 - 32'd4;
        end else if (exp_en) begin
            m_live = 1'b1;
            m_pc = exp_addr;
        end
        @(negedge clk);
    endtask
    initial begin
        reset = 1'b1;
        bus.allow_2 = 1'b0;
        bus.br_taken = 1'b0;
        bus.br_target = '0;
        @(negedge clk);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 32'h1C000100);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h1C000200);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 32'hFFFFFFFC);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 32'h1C000400);
        step(0, 0, 1, 32'h1C000800);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 15, $urandom & ~32'h3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h1C000000, address of the first instruction fetched after reset.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 allow_2  in  1  decode stage can accept an instruction this cycle.
REQ-005 br_taken  in  1  decode stage redirects fetch this cycle.
REQ-006 br_target  in  32  redirect address, valid when br_taken=1.
REQ-007 valid_1  out  1  stage_1_to_2 holds a live instruction.
REQ-008 stage_1_to_2  out  64  {inst[31:0], pc[31:0]}, with inst in the upper half.
REQ-009 inst_sram_en  out  1  instruction SRAM read enable.
REQ-010 inst_sram_we  out  4  byte write enables; tied to 0.
REQ-011 inst_sram_addr  out  32  fetch address.
REQ-012 inst_sram_wdata  out  32  write data; tied to 0.
REQ-013 inst_sram_rdata  in  32  read data, returned 1 cycle after the enabled request.

Function
REQ-014 The block SHALL have two sub-stages: pre-IF (computes nextpc, issues the SRAM request) and IF (holds pc_r, if_valid, buf_valid, buf_inst).
REQ-015 nextpc SHALL be br_target when br_taken=1, else pc_r+4, using 32-bit wrap-around arithmetic.
REQ-016 inst_sram_addr SHALL be {nextpc[31:2],2'b00}.
REQ-017 if_allowin SHALL be ~if_valid | allow_2 | br_taken.
REQ-018 inst_sram_en SHALL be ~reset & if_allowin.
REQ-019 On each edge with inst_sram_en=1: pc_r<=nextpc, if_valid<=1, buf_valid<=0.
REQ-020 valid_1 SHALL be if_valid & ~br_taken, so the wrong-path instruction in IF never transfers.
REQ-021 The transfer rule SHALL be: an instruction moves to decode exactly on an edge where valid_1=1 and allow_2=1.
REQ-022 The inst field SHALL be buf_inst when buf_valid=1, else inst_sram_rdata; the pc field SHALL be pc_r.
REQ-023 IF state machine:
  - EMPTY: if_valid=0.
  - LIVE: if_valid=1, buf_valid=0; SRAM data presented this cycle.
  - HELD: if_valid=1, buf_valid=1.
REQ-024 Transition LIVE->HELD occurs when allow_2=0 and br_taken=0: buf_inst<=inst_sram_rdata, buf_valid<=1, pc_r held.
REQ-025 In HELD, the SRAM SHALL NOT be re-enabled until allow_2=1 or br_taken=1; pc_r and buf_inst stay stable.
REQ-026 HELD/LIVE -> LIVE on a transfer, via the new request issued that same cycle.
REQ-027 br_taken=1 in any state SHALL redirect: the next cycle is LIVE at br_target, and buf_valid is cleared.
REQ-028 br_taken has priority over allow_2=0.
REQ-029 Back-to-back br_taken on consecutive cycles: each redirect wins; the last br_target is fetched.
REQ-030 Throughput SHALL be one instruction per cycle when allow_2=1 and no redirect occurs; fetch-to-valid_1 latency is 1 cycle.

Reset
REQ-031 While reset=1: pc_r<=RESET_PC-4, if_valid<=0, buf_valid<=0, buf_inst<=0; inst_sram_en=0, valid_1=0.
REQ-032 The first request after reset deasserts SHALL be to RESET_PC.
REQ-033 Reset mid-stall or mid-redirect SHALL discard all in-flight state, with no pending redirect retained.

Structure
REQ-034 RESET_PC and the {inst,pc} bus width (64) SHALL live in a shared CPU package together with the stage-bus widths.
REQ-035 One natural sub-module: fetch_inst_buffer, a 1-entry hold register with capture/clear/bypass.

Verification
REQ-036 Reset release with allow_2=1 -> first addr 0x1C000000; valid_1=1 the next cycle with pc 0x1C000000; then 0x1C000004, 0x1C000008 on consecutive cycles.
REQ-037 allow_2=0 for 3 cycles while IF holds pc 0x1C000008 and inst 0x02800C21 -> SRAM en=0 after the first stall cycle; output stable at {0x02800C21,0x1C000008}; after release, 0x1C00000C is issued.
REQ-038 br_taken=1 with br_target=0x1C000100 while IF holds 0x1C000010 -> valid_1=0 that cycle; next cycle pc=0x1C000100, valid_1=1; 0x1C000010 is never transferred.
REQ-039 br_taken=1 with allow_2=0 while in HELD -> buffer cleared; next cycle LIVE at br_target.
REQ-040 reset=1 asserted during HELD -> valid_1=0 next cycle; restart fetch at 0x1C000000.
REQ-041 pc_r=0xFFFFFFFC, no branch -> next fetch addr 0x00000000.
